// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared channel state type, button indices and priority arbiter
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE_DB
  } btn_state_t;

  localparam int NUM_BTN  = 4;
  localparam int IDX_INC  = 0;
  localparam int IDX_INC1 = 1;
  localparam int IDX_DEC  = 2;
  localparam int IDX_DEC1 = 3;

  // Highest priority first: dec1 > dec > inc1 > inc.
  localparam int PRIO_ORDER [NUM_BTN] = '{IDX_DEC1, IDX_DEC, IDX_INC1, IDX_INC};

  function automatic logic [NUM_BTN-1:0] prio_grant(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] grant;
    logic               found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!found && req[PRIO_ORDER[i]]) begin
        grant[PRIO_ORDER[i]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - per-button synchronizer, saturating counter and debounce FSM
// Auto-repeat (HELD->REPEAT and periodic strobes) is compiled in only with BTN_AUTOREPEAT_EN.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_RATE     = 10000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_n,
  output logic o_strobe,
  output logic o_held
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t DB_CNT  = cnt_t'(DEBOUNCE_CYCLES);
`ifdef BTN_AUTOREPEAT_EN
  localparam cnt_t RPT_DELAY_CNT = cnt_t'(REPEAT_DELAY);
  localparam cnt_t RPT_RATE_CNT  = cnt_t'(REPEAT_RATE);
`endif

  logic       r_sync1;
  logic       r_sync2;
  btn_state_t r_state;
  btn_state_t w_state_nxt;
  cnt_t       r_cnt;
  cnt_t       w_cnt_nxt;
  cnt_t       w_cnt_inc;
  logic       r_strobe;
  logic       w_strobe_nxt;
  logic       w_low;

  assign w_low     = ~r_sync2;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + cnt_t'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_sync1  <= i_btn_n;
      r_sync2  <= r_sync1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_strobe_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_low) begin
          w_state_nxt = ST_PRESS_DB;
          w_cnt_nxt   = cnt_t'(1);
        end
      end
      ST_PRESS_DB: begin
        if (!w_low) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_CNT) begin
          w_state_nxt  = ST_HELD;
          w_strobe_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_HELD: begin
        if (!w_low) begin
          w_state_nxt = ST_RELEASE_DB;
          w_cnt_nxt   = cnt_t'(1);
`ifdef BTN_AUTOREPEAT_EN
        end else if (r_cnt == RPT_DELAY_CNT) begin
          w_state_nxt  = ST_REPEAT;
          w_strobe_nxt = 1'b1;
          w_cnt_nxt    = '0;
`endif
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      ST_REPEAT: begin
        if (!w_low) begin
          w_state_nxt = ST_RELEASE_DB;
          w_cnt_nxt   = cnt_t'(1);
        end else if (r_cnt == RPT_RATE_CNT) begin
          w_strobe_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
`endif
      ST_RELEASE_DB: begin
        // A re-press during release debounce resumes HELD and restarts the repeat delay.
        if (w_low) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_CNT) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_strobe = r_strobe;
  assign o_held   = (r_state == ST_HELD) || (r_state == ST_REPEAT) ||
                    (r_state == ST_RELEASE_DB);

endmodule

// File: rtl/btn_step_conditioner.sv
// rtl/btn_step_conditioner.sv - four debounced button channels with fixed-priority strobe arbitration
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_step_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_RATE     = 10000
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                inc_btn,
  input  logic                inc1_btn,
  input  logic                dec_btn,
  input  logic                dec1_btn,
  output logic                inc,
  output logic                inc1,
  output logic                dec,
  output logic                dec1,
  output logic [NUM_BTN-1:0]  held
);

  logic [NUM_BTN-1:0] w_btn_n;
  logic [NUM_BTN-1:0] w_strobe;
  logic [NUM_BTN-1:0] w_grant;

  assign w_btn_n[IDX_INC]  = inc_btn;
  assign w_btn_n[IDX_INC1] = inc1_btn;
  assign w_btn_n[IDX_DEC]  = dec_btn;
  assign w_btn_n[IDX_DEC1] = dec1_btn;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .i_clk   (clkin),
      .i_reset (reset),
      .i_btn_n (w_btn_n[g]),
      .o_strobe(w_strobe[g]),
      .o_held  (held[g])
    );
  end

  // Losing strobes are dropped outright, never deferred.
  assign w_grant = prio_grant(w_strobe);

  assign inc  = ~w_grant[IDX_INC];
  assign inc1 = ~w_grant[IDX_INC1];
  assign dec  = ~w_grant[IDX_DEC];
  assign dec1 = ~w_grant[IDX_DEC1];

endmodule

// File: tb/tb_btn_step_conditioner.sv
// tb/tb_btn_step_conditioner.sv - scoreboard bench: expected strobes queued by stimulus, checked by a monitor
module tb_btn_step_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       inc_btn, inc1_btn, dec_btn, dec1_btn;
  logic       inc, inc1, dec, dec1;
  logic [3:0] held;

  typedef struct {
    int edge_no;
    int id;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   k;
  int   k2;

  btn_step_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (5)
  ) dut (
    .clkin   (clk),
    .reset   (reset),
    .inc_btn (inc_btn),
    .inc1_btn(inc1_btn),
    .dec_btn (dec_btn),
    .dec1_btn(dec1_btn),
    .inc     (inc),
    .inc1    (inc1),
    .dec     (dec),
    .dec1    (dec1),
    .held    (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int e, input int id);
    exp_t x;
    x.edge_no = e;
    x.id      = id;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Strobe monitor: compares each observed strobe against the head of the queue.
  always @(negedge clk) begin
    logic [3:0] lo;
    int         id;
    exp_t       e;
    while (q.size() > 0 && q[0].edge_no < edge_cnt) begin
      checks++;
      errors++;
      $display("FAIL missing_strobe: expected id %0d after edge %0d, got no strobe", q[0].id, q[0].edge_no);
      void'(q.pop_front());
    end
    lo = ~{dec1, dec, inc1, inc};
    if (lo !== 4'h0) begin
      checks++;
      id = (lo === 4'b0001) ? 0 : (lo === 4'b0010) ? 1 :
           (lo === 4'b0100) ? 2 : (lo === 4'b1000) ? 3 : -1;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got lines %b after edge %0d, expected none", lo, edge_cnt);
      end else begin
        e = q.pop_front();
        if (id != e.id || edge_cnt != e.edge_no) begin
          errors++;
          $display("FAIL strobe: got id %0d (lines %b) after edge %0d, expected id %0d after edge %0d",
                   id, lo, edge_cnt, e.id, e.edge_no);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    inc_btn  = 1'b1;
    inc1_btn = 1'b1;
    dec_btn  = 1'b1;
    dec1_btn = 1'b1;
    reset    = 1'b1;
    tick();
    tick();
    chk("reset_strobes", {28'h0, inc, inc1, dec, dec1}, 32'hF);
    chk("reset_held", {28'h0, held}, 32'h0);
    reset = 1'b0;
    tick();
    tick();

    // Clean press on inc
    k = edge_cnt + 1;
    push(k + 6, 0);
    inc_btn = 1'b0;
    while (edge_cnt < k + 5) tick();
    chk("clean_held_before", {31'h0, held[0]}, 32'h0);
    tick();
    chk("clean_held_after", {31'h0, held[0]}, 32'h1);
    while (edge_cnt < k + 9) tick();
    inc_btn = 1'b1;
    repeat (12) tick();
    chk("clean_release_held", {28'h0, held}, 32'h0);

    // Bounce on dec: two cycles low, two high
    for (int i = 0; i < 20; i++) begin
      dec_btn = ((i % 4) < 2) ? 1'b0 : 1'b1;
      tick();
      chk("bounce_held", {31'h0, held[2]}, 32'h0);
    end
    dec_btn = 1'b1;
    repeat (8) tick();

    // Long hold on inc1
    k = edge_cnt + 1;
    push(k + 6, 1);
`ifdef BTN_AUTOREPEAT_EN
    for (int n = 27; n <= 57; n += 6) push(k + n, 1);
`endif
    inc1_btn = 1'b0;
    repeat (60) tick();
    inc1_btn = 1'b1;
    repeat (15) tick();
    chk("hold_release_held", {28'h0, held}, 32'h0);

    // Simultaneous inc and dec1
    k = edge_cnt + 1;
    push(k + 6, 3);
    inc_btn  = 1'b0;
    dec1_btn = 1'b0;
    repeat (10) tick();
    chk("simul_held", {28'h0, held}, 32'h9);
    inc_btn  = 1'b1;
    dec1_btn = 1'b1;
    repeat (12) tick();
    chk("simul_release_held", {28'h0, held}, 32'h0);

    // Release bounce on inc
    k = edge_cnt + 1;
    push(k + 6, 0);
    inc_btn = 1'b0;
    while (edge_cnt < k + 7) tick();
    inc_btn = 1'b1;
    tick();
    tick();
    inc_btn = 1'b0;
    while (edge_cnt < k + 14) begin
      tick();
      chk("relbounce_held", {31'h0, held[0]}, 32'h1);
    end
    inc_btn = 1'b1;
    while (edge_cnt < k + 20) tick();
    chk("reldb_last_held", {31'h0, held[0]}, 32'h1);
    tick();
    chk("reldb_done_held", {31'h0, held[0]}, 32'h0);
    repeat (4) tick();

    // Reset while dec is held
    k = edge_cnt + 1;
    push(k + 6, 2);
    dec_btn = 1'b0;
    while (edge_cnt < k + 8) tick();
    chk("pre_reset_held", {31'h0, held[2]}, 32'h1);
    reset = 1'b1;
    tick();
    chk("midreset_strobes", {28'h0, inc, inc1, dec, dec1}, 32'hF);
    chk("midreset_held", {28'h0, held}, 32'h0);
    reset = 1'b0;
    k2 = edge_cnt + 1;
    push(k2 + 6, 2);
    while (edge_cnt < k2 + 5) tick();
    chk("rearm_held_before", {31'h0, held[2]}, 32'h0);
    tick();
    chk("rearm_held_after", {31'h0, held[2]}, 32'h1);
    repeat (3) tick();
    dec_btn = 1'b1;
    repeat (12) tick();

    begin
      int n;
      n = 0;
      while (q.size() > 0 && n < 50) begin
        tick();
        n++;
      end
    end
    chk("queue_drained", q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
